wb_gpio_irq: RTL and testbench

Parametrised Wishbone GPIO slave, successor to the fixed 8-bit GPIO block: 1–32 bidirectional pins, per-bit direction, atomic set/clear of outputs, two-flop input synchronisers, and per-bit edge-triggered interrupts with mask, polarity and write-1-to-clear pending bits. It sits on the LM32 Wishbone data bus and drives one level interrupt line to the CPU interrupt controller.

---
 rtl/wb_gpio_irq.sv | 151 +++++++++++++++
 tb/tb_wb_gpio_irq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone GPIO slave with per-bit direction, atomic set/clear,
// two-flop input synchronisers and edge-triggered, maskable interrupts.
//
// Build option: define WB_GPIO_IRQ_EN to build the interrupt logic
// (IRQ_MASK / IRQ_POL / IRQ_PEND, warm-up counter, edge detect). Without it,
// word addresses 5-7 read 0 and ignore writes, and irq_o is tied to 0.
//
// Ports:
//   clk, rst    single clock, synchronous active-high reset
//   wb_adr_i    byte address, word select on [4:2]
//   wb_dat_i    write data (bits above gpio_io_width ignored)
//   wb_we_i     write enable
//   wb_cyc_i    bus cycle
//   wb_stb_i    strobe
//   wb_ack_o    one-cycle acknowledge
//   wb_dat_o    registered read data, unused upper bits 0
//   gpio_io     bidirectional pins, driven from DATA_OUT where DIR = 1
//   irq_o       registered level interrupt
module wb_gpio_irq #(
  parameter int unsigned gpio_io_width      = 8,
  parameter logic [31:0] gpio_dir_reset_val = 32'h0,
  parameter logic [31:0] gpio_o_reset_val   = 32'h0,
  parameter int unsigned wb_dat_width       = 32,
  parameter int unsigned wb_adr_width       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [wb_adr_width-1:0]  wb_adr_i,
  input  logic [wb_dat_width-1:0]  wb_dat_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic                     wb_ack_o,
  output logic [wb_dat_width-1:0]  wb_dat_o,
  inout  wire  [gpio_io_width-1:0] gpio_io,
  output logic                     irq_o
);

  localparam int unsigned GpioW = gpio_io_width;

  logic             r_ack;
  logic [31:0]      r_dat_o;
  logic [GpioW-1:0] r_data_out;
  logic [GpioW-1:0] r_dir;
  logic [GpioW-1:0] r_sync1;
  logic [GpioW-1:0] r_sync2;

  logic [2:0]       w_addr;
  logic             w_access;
  logic             w_wr;
  logic [GpioW-1:0] w_wdat;
  logic [GpioW-1:0] w_rval;
  logic             w_unused;

  assign w_addr   = wb_adr_i[4:2];
  // Access only while ack is low, so a held strobe is served every other cycle.
  assign w_access = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr     = w_access & wb_we_i;
  assign w_wdat   = wb_dat_i[GpioW-1:0];
  assign w_unused = ^{wb_adr_i, wb_dat_i};

  assign wb_ack_o = wb_stb_i & wb_cyc_i & r_ack;
  assign wb_dat_o = r_dat_o;

  for (genvar gi = 0; gi < GpioW; gi++) begin : g_pad
    assign gpio_io[gi] = r_dir[gi] ? r_data_out[gi] : 1'bz;
  end

`ifdef WB_GPIO_IRQ_EN
  logic [GpioW-1:0] r_prev;
  logic [GpioW-1:0] r_mask;
  logic [GpioW-1:0] r_pol;
  logic [GpioW-1:0] r_pend;
  logic [1:0]       r_warm;
  logic             r_irq;
  logic [GpioW-1:0] w_edge;
  logic [GpioW-1:0] w_w1c;

  // Until the sync chain and prev have filled with real pin samples, a pin held
  // high through reset would look like a rising edge; suppress edges meanwhile.
  assign w_edge = (r_warm == 2'd3) ?
                  ((r_sync2 & ~r_prev & r_pol) | (~r_sync2 & r_prev & ~r_pol)) : '0;
  assign w_w1c  = (w_wr && (w_addr == 3'd7)) ? w_wdat : '0;
  assign irq_o  = r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_mask <= '0;
      r_pol  <= '1;
      r_pend <= '0;
      r_warm <= 2'd0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= r_sync2;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
      if (w_wr && (w_addr == 3'd5)) r_mask <= w_wdat;
      if (w_wr && (w_addr == 3'd6)) r_pol  <= w_wdat;
      // A new edge wins over a simultaneous clear of the same bit.
      r_pend <= (r_pend & ~w_w1c) | w_edge;
      r_irq  <= |(r_pend & r_mask);
    end
  end
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    w_rval = '0;
    case (w_addr)
      3'd0:    w_rval = r_sync2;
      3'd1:    w_rval = r_data_out;
      3'd2:    w_rval = r_dir;
`ifdef WB_GPIO_IRQ_EN
      3'd5:    w_rval = r_mask;
      3'd6:    w_rval = r_pol;
      3'd7:    w_rval = r_pend;
`endif
      default: w_rval = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_dat_o    <= '0;
      r_data_out <= gpio_o_reset_val[GpioW-1:0];
      r_dir      <= gpio_dir_reset_val[GpioW-1:0];
      r_sync1    <= '0;
      r_sync2    <= '0;
    end else begin
      r_ack   <= w_access;
      r_sync1 <= gpio_io;
      r_sync2 <= r_sync1;
      if (w_access) begin
        r_dat_o              <= '0;
        r_dat_o[GpioW-1:0]   <= w_rval;
      end
      if (w_wr) begin
        case (w_addr)
          3'd1:    r_data_out <= w_wdat;
          3'd2:    r_dir      <= w_wdat;
          3'd3:    r_data_out <= r_data_out | w_wdat;
          3'd4:    r_data_out <= r_data_out & ~w_wdat;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq (8 pins, default reset values).
module tb_wb_gpio_irq;

  localparam int W = 8;
`ifdef WB_GPIO_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, wdat;
  logic        we, cyc, stb;
  wire         ack;
  wire  [31:0] rdat;
  wire  [W-1:0] pins;
  wire         irq;
  logic [W-1:0] tb_pin;
  logic [W-1:0] drv_dir;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wb_gpio_irq #(.gpio_io_width(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_ack_o (ack),
    .wb_dat_o (rdat),
    .gpio_io  (pins),
    .irq_o    (irq)
  );

  // Bench drives only the pins the design is not driving.
  for (genvar g = 0; g < W; g++) begin : g_drv
    assign pins[g] = drv_dir[g] ? 1'bz : tb_pin[g];
  end

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_dout, m_dir, m_mask, m_pol, m_pend;
  logic         m_ack, m_irq;
  logic [31:0]  m_rdat;
  int           m_n;            // clock edges since reset
  logic [W-1:0] m_hist[$];      // pin value seen at each edge since reset

  // Pin sample taken b edges ago (1 = most recent); before reset history is 0.
  function automatic logic [W-1:0] past(int b);
    if (m_hist.size() < b) return '0;
    return m_hist[m_hist.size() - b];
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] pin, s2, pv, edg, w1c, rv;
    logic         acc;
    if (rst) begin
      m_dout = '0; m_dir = '0; m_mask = '0; m_pol = '1; m_pend = '0;
      m_ack = 1'b0; m_irq = 1'b0; m_rdat = '0; m_n = 0;
      m_hist.delete();
    end else begin
      pin = (m_dir & m_dout) | (~m_dir & tb_pin);
      m_n = m_n + 1;
      s2 = past(2);   // synchronised value visible as DATA_IN
      pv = past(3);
      edg = '0;
      if (IrqEn && m_n >= 4)
        for (int i = 0; i < W; i++)
          edg[i] = m_pol[i] ? (s2[i] && !pv[i]) : (!s2[i] && pv[i]);
      acc = cyc && stb && !m_ack;
      case (adr[4:2])
        3'd0: rv = s2;
        3'd1: rv = m_dout;
        3'd2: rv = m_dir;
        3'd5: rv = IrqEn ? m_mask : '0;
        3'd6: rv = IrqEn ? m_pol : '0;
        3'd7: rv = IrqEn ? m_pend : '0;
        default: rv = '0;
      endcase
      m_irq = IrqEn && ((m_pend & m_mask) != 0);
      w1c = '0;
      if (acc && we) begin
        case (adr[4:2])
          3'd1: m_dout = wdat[W-1:0];
          3'd2: m_dir  = wdat[W-1:0];
          3'd3: m_dout = m_dout | wdat[W-1:0];
          3'd4: m_dout = m_dout & ~wdat[W-1:0];
          3'd5: m_mask = wdat[W-1:0];
          3'd6: m_pol  = wdat[W-1:0];
          3'd7: w1c    = wdat[W-1:0];
          default: ;
        endcase
      end
      m_pend = (m_pend & ~w1c) | edg;
      if (acc) m_rdat = {24'b0, rv};
      m_ack = acc;
      m_hist.push_back(pin);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
    end
  end

  always @(posedge clk) begin
    #1 drv_dir = m_dir;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", {31'b0, ack}, {31'b0, cyc & stb & m_ack});
      if (cyc && stb && m_ack) chk("rdat", rdat, m_rdat);
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
      chk("pins_out", {24'b0, pins & m_dir}, {24'b0, m_dout & m_dir});
    end
  end

  // ---------------- bus helpers (called just after a rising edge) ----------------
  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    adr = {27'b0, a, 2'b00}; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("ack_seen", {31'b0, ack}, 32'h1);
    r = rdat;
    #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 32'h0, r);
    chk(name, r, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [31:0] rst_exp [8];
  int          acks;

  initial begin
    rst = 1'b1; adr = '0; wdat = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0; tb_pin = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // Reset values of all eight words.
    rst_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                (IrqEn ? 32'hFF : 32'h0), 32'h0};
    for (int a = 0; a < 8; a++) rd_chk($sformatf("reset_rd%0d", a), 3'(a), rst_exp[a]);
    chk("reset_irq", {31'b0, irq}, 32'h0);

    // Direction, data, set/clear.
    wr(3'd2, 32'hF0);
    wr(3'd1, 32'hA5);
    wr(3'd3, 32'h0F);
    wr(3'd4, 32'h80);
    rd_chk("dout_2f", 3'd1, 32'h2F);
    chk("pins_hi", {28'b0, pins[7:4]}, 32'h2);
    rd_chk("din_20", 3'd0, 32'h20);

    // Interrupt on pin0 rising, pin1 falling with POL[1] = 0.
    wr(3'd7, 32'hFF);
    wr(3'd5, 32'h01);
    wr(3'd6, 32'h01);
    tb_pin[0] = 1'b1;
    idle(4);
    rd_chk("pend_rise", 3'd7, IrqEn ? 32'h01 : 32'h0);
    chk("irq_rise", {31'b0, irq}, {31'b0, IrqEn});
    wr(3'd7, 32'h01);
    rd_chk("pend_w1c", 3'd7, 32'h0);
    chk("irq_w1c", {31'b0, irq}, 32'h0);
    tb_pin[1] = 1'b1;
    idle(4);
    tb_pin[1] = 1'b0;
    idle(4);
    rd_chk("pend_fall", 3'd7, IrqEn ? 32'h02 : 32'h0);
    chk("irq_fall_masked", {31'b0, irq}, 32'h0);

    // W1C colliding with a fresh edge on the same bit.
    wr(3'd7, 32'hFF);
    tb_pin[0] = 1'b0; idle(4);
    tb_pin[0] = 1'b1; idle(4);
    tb_pin[0] = 1'b0; idle(4);
    tb_pin[0] = 1'b1;
    idle(2);
    wr(3'd7, 32'h01);
    rd_chk("pend_collide", 3'd7, IrqEn ? 32'h01 : 32'h0);
    chk("irq_collide", {31'b0, irq}, {31'b0, IrqEn});

    // Pin held high through reset must not register an edge.
    rst = 1'b1; idle(2);
    rst = 1'b0;
    wr(3'd5, 32'h01);
    idle(20);
    rd_chk("pend_warm", 3'd7, 32'h0);
    chk("irq_warm", {31'b0, irq}, 32'h0);

    // Held strobe: acked every second cycle.
    adr = 32'h4; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("b2b_acks", 32'(acks), 32'd3);
    @(posedge clk); #2 cyc = 1'b0; stb = 1'b0;
    idle(1);

    // Randomised traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      cyc  = ($urandom_range(0, 3) != 0);
      stb  = ($urandom_range(0, 2) != 0);
      we   = $urandom_range(0, 1) == 1;
      adr  = $urandom;
      wdat = $urandom;
      if ($urandom_range(0, 3) == 0) tb_pin = tb_pin ^ W'($urandom);
      @(posedge clk); #2;
    end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
